// File: rtl/cache_def.sv
// Shared L1 cache geometry and the refill controller state encoding.
package cache_def;

  localparam int unsigned INDEX_L1     = 6;
  localparam int unsigned INDEX_WAY_L1 = 2;
  localparam int unsigned NUM_WAYS_L1  = 4;

  typedef enum logic [1:0] {
    StIdle,
    StWriteback,
    StAllocate,
    StUpdate
  } refill_state_e;

endpackage

// File: rtl/cache_victim_sel.sv
// Victim way pick for a miss: lowest-numbered invalid way, else the pLRU choice.
module cache_victim_sel
  import cache_def::*;
#(
  parameter int unsigned NUM_WAYS = NUM_WAYS_L1
) (
  input  logic [NUM_WAYS-1:0]     way_valid_i,
  input  logic [INDEX_WAY_L1-1:0] plru_way_i,
  output logic [INDEX_WAY_L1-1:0] victim_way_o
);

  // Scan downward so the lowest invalid way is the last one written.
  always_comb begin
    victim_way_o = plru_way_i;
    for (int i = int'(NUM_WAYS) - 1; i >= 0; i--) begin
      if (!way_valid_i[i]) begin
        victim_way_o = INDEX_WAY_L1'(i);
      end
    end
  end

endmodule

// File: rtl/cache_refill_ctrl.sv
// L1 refill controller: accepts one access, optionally writes back the victim,
// fetches the line, then reports the access to the pLRU tree.
module cache_refill_ctrl
  import cache_def::*;
#(
  parameter int unsigned NUM_WAYS = NUM_WAYS_L1
) (
  input  logic                    clk_i,
  input  logic                    rst_i,

  input  logic                    req_valid_i,
  output logic                    req_ready_o,
  input  logic [INDEX_L1-1:0]     req_index_i,
  input  logic                    hit_i,
  input  logic [INDEX_WAY_L1-1:0] hit_way_i,
  input  logic [NUM_WAYS-1:0]     way_valid_i,
  input  logic [NUM_WAYS-1:0]     way_dirty_i,
  input  logic [INDEX_WAY_L1-1:0] victim_way_i,

  output logic                    plru_valid_o,
  output logic [INDEX_L1-1:0]     plru_index_o,
  output logic [INDEX_WAY_L1-1:0] plru_way_o,

  output logic                    mem_req_o,
  output logic                    mem_we_o,
  output logic [INDEX_L1-1:0]     mem_index_o,
  output logic [INDEX_WAY_L1-1:0] mem_way_o,
  input  logic                    mem_ack_i,

  output logic                    refill_we_o,
  output logic [INDEX_WAY_L1-1:0] refill_way_o,
  output logic                    resp_valid_o
);

  refill_state_e             r_state;
  refill_state_e             w_state_next;
  logic [INDEX_L1-1:0]       r_index;
  logic [INDEX_WAY_L1-1:0]   r_way;
  logic                      r_miss;

  logic [INDEX_WAY_L1-1:0]   w_victim;
  logic                      w_victim_dirty;
  logic                      w_accept;

  cache_victim_sel #(
    .NUM_WAYS (NUM_WAYS)
  ) u_victim_sel (
    .way_valid_i  (way_valid_i),
    .plru_way_i   (victim_way_i),
    .victim_way_o (w_victim)
  );

  assign w_victim_dirty = way_valid_i[w_victim] & way_dirty_i[w_victim];
  assign w_accept       = (r_state == StIdle) && req_valid_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= StIdle;
      r_index <= '0;
      r_way   <= '0;
      r_miss  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_accept) begin
        r_index <= req_index_i;
        r_way   <= hit_i ? hit_way_i : w_victim;
        r_miss  <= ~hit_i;
      end
    end
  end

  // Outputs depend only on state and latched registers, so reset clears them at once.
  always_comb begin
    w_state_next = r_state;
    req_ready_o  = 1'b0;
    plru_valid_o = 1'b0;
    plru_index_o = '0;
    plru_way_o   = '0;
    mem_req_o    = 1'b0;
    mem_we_o     = 1'b0;
    mem_index_o  = '0;
    mem_way_o    = '0;
    refill_we_o  = 1'b0;
    refill_way_o = '0;
    resp_valid_o = 1'b0;

    case (r_state)
      StIdle: begin
        req_ready_o = 1'b1;
        if (req_valid_i) begin
          if (hit_i) begin
            w_state_next = StUpdate;
          end else if (w_victim_dirty) begin
            w_state_next = StWriteback;
          end else begin
            w_state_next = StAllocate;
          end
        end
      end
      StWriteback: begin
        mem_req_o   = 1'b1;
        mem_we_o    = 1'b1;
        mem_index_o = r_index;
        mem_way_o   = r_way;
        if (mem_ack_i) begin
          w_state_next = StAllocate;
        end
      end
      StAllocate: begin
        mem_req_o   = 1'b1;
        mem_index_o = r_index;
        mem_way_o   = r_way;
        if (mem_ack_i) begin
          w_state_next = StUpdate;
        end
      end
      StUpdate: begin
        plru_valid_o = 1'b1;
        plru_index_o = r_index;
        plru_way_o   = r_way;
        resp_valid_o = 1'b1;
        refill_we_o  = r_miss;
        refill_way_o = r_miss ? r_way : '0;
        w_state_next = StIdle;
      end
      default: begin
        w_state_next = StIdle;
      end
    endcase
  end

endmodule

// File: doc/cache_refill_ctrl.md
CACHE_REFILL_CTRL -- requirements
Module: cache_refill_ctrl

Interface
REQ-001 Parameter: NUM_WAYS, default NUM_WAYS_L1 (4), ways per set; SHALL equal 2**INDEX_WAY_L1.
REQ-002 clk_i  in  1  sole clock, rising edge.
REQ-003 rst_i  in  1  asynchronous, active-high reset.
REQ-004 req_valid_i  in  1  core access request.
REQ-005 req_ready_o  out  1  high only in IDLE.
REQ-006 req_index_i  in  INDEX_L1  set index of the request.
REQ-007 hit_i  in  1  tag compare hit, valid with req_valid_i.
REQ-008 hit_way_i  in  INDEX_WAY_L1  hitting way.
REQ-009 way_valid_i  in  NUM_WAYS  valid bits of the indexed set.
REQ-010 way_dirty_i  in  NUM_WAYS  dirty bits of the indexed set.
REQ-011 victim_way_i  in  INDEX_WAY_L1  pLRU victim for the indexed set.
REQ-012 plru_valid_o / plru_index_o / plru_way_o  out  1 / INDEX_L1 / INDEX_WAY_L1  access report to the pLRU tree (drives its valid_i/index_i/address_i).
REQ-013 mem_req_o, mem_we_o  out  1, 1  next-level request; we=1 writeback, we=0 fetch.
REQ-014 mem_index_o, mem_way_o  out  INDEX_L1, INDEX_WAY_L1  set/way of the memory transfer.
REQ-015 mem_ack_i  in  1  one-cycle completion pulse from next level.
REQ-016 refill_we_o, refill_way_o  out  1, INDEX_WAY_L1  data/tag array write for the refilled line.
REQ-017 resp_valid_o  out  1  one-cycle pulse; request complete.

Function
REQ-018 FSM states SHALL be IDLE, WRITEBACK, ALLOCATE, UPDATE; all outputs registered or decoded from state plus latched registers only.
REQ-019 IDLE, req_valid_i=1: index latched; hit_i=1 -> way=hit_way_i, miss=0, next UPDATE.
REQ-020 IDLE miss: victim = lowest-numbered way with way_valid_i=0; if all valid, victim = victim_way_i; sampled in the accept cycle only.
REQ-021 Miss, victim valid and dirty -> WRITEBACK; otherwise -> ALLOCATE.
REQ-022 WRITEBACK: mem_req_o=1, mem_we_o=1 held until mem_ack_i; on ack -> ALLOCATE.
REQ-023 ALLOCATE: mem_req_o=1, mem_we_o=0 held until mem_ack_i; on ack -> UPDATE.
REQ-024 mem_index_o/mem_way_o SHALL equal the latched index/victim during WRITEBACK and ALLOCATE.
REQ-025 UPDATE (exactly one cycle): plru_valid_o=1 with latched index/way; resp_valid_o=1; refill_we_o=1 only for a miss; next IDLE.
REQ-026 Hit latency: accept to resp_valid_o = 1 cycle. Miss latency: 1 cycle plus wait for each mem_ack_i, plus 1.
REQ-027 mem_ack_i outside WRITEBACK/ALLOCATE SHALL be ignored.
REQ-028 req_valid_i while req_ready_o=0 SHALL be ignored (no queuing).
REQ-029 Exactly one plru_valid_o pulse per accepted request; never asserted outside UPDATE.

Reset
REQ-030 rst_i=1 SHALL immediately force IDLE and drive all outputs 0 except req_ready_o=1, including mid-WRITEBACK/ALLOCATE; pending transfer abandoned.
REQ-031 Latched index/way/miss registers SHALL reset to 0.

Structure
REQ-032 INDEX_L1, INDEX_WAY_L1, NUM_WAYS_L1 and the FSM state enum SHALL live in package cache_def.
REQ-033 One sub-module SHALL be natural: cache_victim_sel (combinational invalid-way priority pick plus pLRU fallback).

Verification
REQ-034 Hit: index=5, hit_way=2 -> next cycle plru_valid_o=1, plru_index_o=5, plru_way_o=2, resp_valid_o=1, mem_req_o=0.
REQ-035 Miss, way_valid=4'b1011 -> victim 2, straight to ALLOCATE, no writeback; after ack, refill_we_o=1, refill_way_o=2.
REQ-036 Miss, all valid, victim_way_i=3, dirty=4'b1000 -> WRITEBACK (mem_we_o=1, way 3) then ALLOCATE (mem_we_o=0), ack delay 4 cycles each, resp after both.
REQ-037 Miss, all valid, victim_way_i=1 clean -> ALLOCATE only; victim_way_i changed after accept does not alter mem_way_o.
REQ-038 rst_i asserted mid-ALLOCATE -> same-cycle mem_req_o=0, req_ready_o=1; late mem_ack_i ignored, no resp_valid_o.
REQ-039 Back-to-back req_valid_i while busy -> no extra plru_valid_o; stray mem_ack_i in IDLE -> no state change.
